cache_mem_arbiter: RTL and testbench

CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

---
 rtl/cache_mem_arbiter.sv | 99 +++++++++
 tb/tb_cache_mem_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// Two-requester arbiter sharing one line-granular memory port between the i-cache and d-cache.
// Optional build macro ARB_ROUND_ROBIN_EN switches contention from fixed d-cache priority to alternating grants.
module cache_mem_arbiter (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_read,
    input  logic [31:0]  i_address,
    output logic         i_resp,
    input  logic         d_read,
    input  logic         d_write,
    input  logic [31:0]  d_address,
    input  logic [255:0] d_wdata,
    output logic         d_resp,
    output logic [255:0] rdata,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp
);

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D,
        RELEASE
    } state_t;

    state_t r_state;
    logic   r_lastGrant;
    logic   r_pmemRead;
    logic   r_pmemWrite;
    logic   w_dReq;
    logic   w_grantD;

    assign w_dReq = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
    // On contention the requester that did not win last time gets the port.
    assign w_grantD = w_dReq & (~i_read | ~r_lastGrant);
`else
    logic w_unusedLastGrant;
    assign w_unusedLastGrant = r_lastGrant;
    assign w_grantD = w_dReq;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_lastGrant <= 1'b0;
            r_pmemRead  <= 1'b0;
            r_pmemWrite <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grantD) begin
                        r_state     <= SERVE_D;
                        r_lastGrant <= 1'b1;
                        r_pmemWrite <= d_write;
                        r_pmemRead  <= d_read & ~d_write;
                    end else if (i_read) begin
                        r_state     <= SERVE_I;
                        r_lastGrant <= 1'b0;
                        r_pmemRead  <= 1'b1;
                        r_pmemWrite <= 1'b0;
                    end
                end
                // The operation is captured at grant so a dropped request cannot abort it.
                SERVE_I, SERVE_D: begin
                    if (pmem_resp) begin
                        r_state     <= RELEASE;
                        r_pmemRead  <= 1'b0;
                        r_pmemWrite <= 1'b0;
                    end
                end
                RELEASE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign pmem_read  = r_pmemRead;
    assign pmem_write = r_pmemWrite;
    assign pmem_wdata = d_wdata;
    assign rdata      = pmem_rdata;
    assign i_resp     = (r_state == SERVE_I) & pmem_resp;
    assign d_resp     = (r_state == SERVE_D) & pmem_resp;

    always_comb begin
        pmem_address = 32'h0;
        case (r_state)
            SERVE_I: pmem_address = i_address;
            SERVE_D: pmem_address = d_address;
            default: pmem_address = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: transaction-level reference model, directed scenarios, random traffic.
// Honors ARB_ROUND_ROBIN_EN the same way as the design when computing expected grants.
module tb_cache_mem_arbiter;

    logic         clk;
    logic         rst;
    logic         i_read;
    logic [31:0]  i_address;
    logic         i_resp;
    logic         d_read;
    logic         d_write;
    logic [31:0]  d_address;
    logic [255:0] d_wdata;
    logic         d_resp;
    logic [255:0] rdata;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    int errors = 0;
    int checks = 0;

    // Reference model: who owns the memory port, whether we are in the cool-down cycle, and history.
    int mOwner   = 0;
    bit mRelease = 0;
    bit mLastD   = 0;
    bit mOpRead  = 0;
    bit mOpWrite = 0;
    bit mKnown   = 0;

    cache_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata), .d_resp(d_resp),
        .rdata(rdata),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every DUT output against what the model says the current cycle must show.
    task automatic modelCheck();
        bit expIResp;
        bit expDResp;
        logic [31:0] expAddr;
        expIResp = (mOwner == 1) && pmem_resp;
        expDResp = (mOwner == 2) && pmem_resp;
        expAddr  = (mOwner == 1) ? i_address : (mOwner == 2) ? d_address : 32'h0;
        checkOutput("pmem_read", pmem_read, (mOwner == 1) || (mOwner == 2 && mOpRead));
        checkOutput("pmem_write", pmem_write, mOwner == 2 && mOpWrite);
        checkOutput("pmem_address", pmem_address, expAddr);
        checkOutput("pmem_wdata", pmem_wdata, d_wdata);
        checkOutput("i_resp", i_resp, expIResp);
        checkOutput("d_resp", d_resp, expDResp);
        if (expIResp || expDResp) checkOutput("rdata", rdata, pmem_rdata);
    endtask

    // Advance the model by the clock edge that is about to sample the current inputs.
    task automatic modelStep();
        bit iReq;
        bit dReq;
        bit pickD;
        iReq = i_read;
        dReq = d_read || d_write;
        if (rst) begin
            mOwner = 0; mRelease = 0; mLastD = 0; mKnown = 1;
        end else if (mRelease) begin
            mRelease = 0;
        end else if (mOwner != 0) begin
            if (pmem_resp) begin
                mOwner = 0; mRelease = 1;
            end
        end else if (iReq || dReq) begin
`ifdef ARB_ROUND_ROBIN_EN
            pickD = dReq && (!iReq || !mLastD);
`else
            pickD = dReq;
`endif
            mOwner   = pickD ? 2 : 1;
            mLastD   = pickD;
            mOpWrite = pickD && d_write;
            mOpRead  = pickD ? (d_read && !d_write) : 1'b1;
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, let them settle, check, then step the model.
    task automatic applyStimulus(input bit vRst, input bit vIRead, input logic [31:0] vIAddr,
                                 input bit vDRead, input bit vDWrite, input logic [31:0] vDAddr,
                                 input logic [255:0] vDWdata, input bit vPResp, input logic [255:0] vPRdata);
        @(negedge clk);
        rst = vRst; i_read = vIRead; i_address = vIAddr;
        d_read = vDRead; d_write = vDWrite; d_address = vDAddr; d_wdata = vDWdata;
        pmem_resp = vPResp; pmem_rdata = vPRdata;
        #1;
        if (mKnown) modelCheck();
        modelStep();
    endtask

    logic [255:0] allA5;
    logic [255:0] lineX;
    int           n;
    bit           gotD [3];
    bit           expD [3];

    // Random traffic state.
    bit          iActive, dActive, dRd, dWr, lastPResp, strobeSeen, rRst, rPResp;
    logic [31:0] iAddr, dAddr;
    logic [255:0] dLine;
    int          memWait, op;

    initial begin
        allA5 = {32{8'hA5}};
        lineX = rand256();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("reset_pmem_read", pmem_read, 0);
        checkOutput("reset_pmem_addr", pmem_address, 0);

        // i-cache read with five cycles of memory latency.
        applyStimulus(0, 1, 32'h0000_1000, 0, 0, 0, 0, 0, 0);
        checkOutput("i_arb_latency", pmem_read, 0);
        applyStimulus(0, 1, 32'h0000_1000, 0, 0, 0, 0, 0, 0);
        checkOutput("i_strobe", pmem_read, 1);
        checkOutput("i_address", pmem_address, 32'h0000_1000);
        for (int k = 0; k < 4; k++) applyStimulus(0, 1, 32'h0000_1000, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 32'h0000_1000, 0, 0, 0, 0, 1, lineX);
        checkOutput("i_resp_pulse", i_resp, 1);
        checkOutput("i_rdata", rdata, lineX);
        checkOutput("i_no_d_resp", d_resp, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("release_strobe", pmem_read, 0);
        checkOutput("release_resp", i_resp, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // d-cache write-back.
        applyStimulus(0, 0, 0, 0, 1, 32'h8000_0040, allA5, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 32'h8000_0040, allA5, 0, 0);
        checkOutput("d_write_strobe", pmem_write, 1);
        checkOutput("d_write_no_read", pmem_read, 0);
        checkOutput("d_write_wdata", pmem_wdata, allA5);
        checkOutput("d_write_addr", pmem_address, 32'h8000_0040);
        applyStimulus(0, 0, 0, 0, 1, 32'h8000_0040, allA5, 1, 0);
        checkOutput("d_write_resp", d_resp, 1);
        checkOutput("d_write_no_i_resp", i_resp, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Stray memory response in IDLE, then read+write together behaves as a write.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, lineX);
        checkOutput("stray_i_resp", i_resp, 0);
        checkOutput("stray_d_resp", d_resp, 0);
        applyStimulus(0, 0, 0, 1, 1, 32'h0000_2000, lineX, 0, 0);
        checkOutput("stray_no_state", pmem_read, 0);
        applyStimulus(0, 0, 0, 1, 1, 32'h0000_2000, lineX, 0, 0);
        checkOutput("rw_write_wins", pmem_write, 1);
        checkOutput("rw_no_read", pmem_read, 0);
        applyStimulus(0, 0, 0, 1, 1, 32'h0000_2000, lineX, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Dropping the request mid-grant still completes the transaction.
        applyStimulus(0, 1, 32'h0000_3000, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 32'h0000_3000, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 32'h0000_3000, 0, 0, 0, 0, 0, 0);
        checkOutput("drop_holds_strobe", pmem_read, 1);
        applyStimulus(0, 0, 32'h0000_3000, 0, 0, 0, 0, 1, lineX);
        checkOutput("drop_still_resp", i_resp, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset two cycles into a d-cache grant abandons it.
        applyStimulus(0, 0, 0, 1, 0, 32'h0000_4000, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 32'h0000_4000, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 0, 32'h0000_4000, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, lineX);
        checkOutput("rst_abandon_strobe", pmem_read, 0);
        checkOutput("rst_abandon_addr", pmem_address, 0);
        checkOutput("rst_abandon_d_resp", d_resp, 0);

        // Contention held over three transactions.
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef ARB_ROUND_ROBIN_EN
        expD = '{1'b1, 1'b0, 1'b1};
`else
        expD = '{1'b1, 1'b1, 1'b1};
`endif
        for (int t = 0; t < 3; t++) begin
            n = 0;
            do begin
                applyStimulus(0, 1, 32'h0000_5000, 1, 0, 32'h0000_6000, 0, 0, 0);
                n++;
            end while (!(pmem_read || pmem_write) && n < 10);
            if (n >= 10) begin
                checks++; errors++;
                $display("[TB] FAIL contention_timeout: no strobe after %0d cycles, expected within 3", n);
            end
            checkOutput("contention_latency", n, (t == 0) ? 2 : 3);
            applyStimulus(0, 1, 32'h0000_5000, 1, 0, 32'h0000_6000, 0, 1, lineX);
            gotD[t] = d_resp;
            checkOutput("contention_grant", gotD[t], expD[t]);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Random traffic: requesters hold until their resp, memory answers after 1-5 cycles, occasional strays and resets.
        iActive = 0; dActive = 0; memWait = 0; lastPResp = 0;
        iAddr = 0; dAddr = 0; dLine = 0; dRd = 0; dWr = 0;
        for (int c = 0; c < 3000; c++) begin
            strobeSeen = pmem_read || pmem_write;
            if (i_resp) iActive = 0;
            if (d_resp) dActive = 0;
            if (!iActive && $urandom_range(0, 2) == 0) begin
                iActive = 1; iAddr = $urandom;
            end
            if (!dActive && $urandom_range(0, 2) == 0) begin
                dActive = 1; dAddr = $urandom; dLine = rand256(); op = $urandom_range(0, 2);
                dRd = (op != 1); dWr = (op != 0);
            end
            rPResp = 0;
            if (memWait == 1) begin
                rPResp = 1; memWait = 0;
            end else if (memWait > 1) begin
                memWait--;
            end else if (strobeSeen && !lastPResp) begin
                memWait = $urandom_range(1, 5);
            end else if ($urandom_range(0, 24) == 0) begin
                rPResp = 1;
            end
            lastPResp = rPResp;
            rRst = ($urandom_range(0, 59) == 0);
            applyStimulus(rRst, iActive, iAddr, dActive && dRd, dActive && dWr, dAddr, dLine, rPResp, rand256());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
